// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared definitions for the FFT bit-reversal reorder buffer.
// Frame-size and sample-width defaults live here so every file that includes
// the FFT build sees one value; an external define file takes precedence.
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif
`ifndef C2LOG_FFT_POINTS
`define C2LOG_FFT_POINTS 4
`endif

package fft_bitrev_reorder_pkg;

  // Read-side sequencer states.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port frame buffer: one write port, one synchronous read port.
// The caller places the ping-pong bank bit in the address MSB. The read
// register returns zero on cycles without a read, so its output can drive
// the block outputs directly.
module fft_reorder_ram #(
  parameter int AW = 5,
  parameter int WW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [WW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [WW-1:0] rd_data
);

  localparam int DEPTH = 1 << AW;

  logic [WW-1:0] mem [DEPTH];

  // Write port.
  // NOTE: the storage array has no reset, so it can map onto RAM macros;
  // stale contents are never visible because the full flags gate all reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; forced to zero when no read is issued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Converts FFT output from bit-reversed order to natural bin order.
// Samples are written into a ping-pong pair of frame banks at bit-reversed
// addresses; a completed bank is read out sequentially while the next frame
// fills the other bank, giving gapless output for continuous input.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int LOG2N = `C2LOG_FFT_POINTS,
  parameter int DW    = `DATA_IN_WIDTH
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          di_en,
  input  logic [DW-1:0] di_re,
  input  logic [DW-1:0] di_im,
  output logic          do_en,
  output logic [DW-1:0] do_re,
  output logic [DW-1:0] do_im
);

  localparam logic [LOG2N-1:0] LAST = '1;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  logic [LOG2N-1:0] wcnt;
  logic             wb;
  logic [1:0]       full;
  logic             wr_done;

  rd_state_e        state, state_nxt;
  logic [LOG2N-1:0] rcnt, rcnt_nxt;
  logic             rb, rb_nxt;
  logic             rd_issue;
  logic             rd_done;

  assign wr_done = di_en && (wcnt == LAST);

  // Writer: count accepted samples, abandon a frame when di_en drops early.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt <= '0;
      wb   <= 1'b0;
    end else if (di_en) begin
      wcnt <= wcnt + 1'b1;
      if (wr_done) wb <= ~wb;
    end else begin
      wcnt <= '0;
    end
  end

  // Bank-full flags: writer sets one bank while reader may clear the other.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full <= 2'b00;
    end else begin
      if (wr_done) full[wb] <= 1'b1;
      if (rd_done) full[rb] <= 1'b0;
    end
  end

  // Read sequencer state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      rcnt  <= '0;
      rb    <= 1'b0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      rb    <= rb_nxt;
    end
  end

  // Read sequencer next state: drain a full bank, chain into the other if ready.
  // NOTE: every output gets a default first, so no path can infer a latch;
  // combinational blocks use blocking assignments.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rb_nxt    = rb;
    rd_issue  = 1'b0;
    rd_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (full[rb]) begin
          state_nxt = S_READ;
          rcnt_nxt  = '0;
        end
      end
      S_READ: begin
        rd_issue = 1'b1;
        rcnt_nxt = rcnt + 1'b1;
        if (rcnt == LAST) begin
          rd_done   = 1'b1;
          rb_nxt    = ~rb;
          rcnt_nxt  = '0;
          state_nxt = full[~rb] ? S_READ : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output valid follows the read strobe by the RAM read latency.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) do_en <= 1'b0;
    else       do_en <= rd_issue;
  end

  fft_reorder_ram #(
    .AW (LOG2N + 1),
    .WW (2 * DW)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (di_en),
    .wr_addr ({wb, bitrev(wcnt)}),
    .wr_data ({di_re, di_im}),
    .rd_en   (rd_issue),
    .rd_addr ({rb, rcnt}),
    .rd_data ({do_re, do_im})
  );

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder (N=16, DW=16).
// Stimulus pushes each completed frame's natural-order bins into a queue;
// a monitor pops and compares whenever do_en is high, and also tracks burst
// length, inter-burst gap and first-output latency.
module tb_fft_bitrev_reorder;

  localparam int LOG2N = 4;
  localparam int N     = 16;
  localparam int DW    = 16;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sample_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          di_en = 1'b0;
  logic [DW-1:0] di_re = '0;
  logic [DW-1:0] di_im = '0;
  logic          do_en;
  logic [DW-1:0] do_re;
  logic [DW-1:0] do_im;

  sample_t sb[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int sample0_cyc = -1;
  bit lat_arm     = 1'b0;
  int exp_burst   = 0;
  int exp_gap     = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_bitrev_reorder #(
    .LOG2N (LOG2N),
    .DW    (DW)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .di_en (di_en),
    .di_re (di_re),
    .di_im (di_im),
    .do_en (do_en),
    .do_re (do_re),
    .do_im (do_im)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LOG2N-1:0] rev4(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Value of natural-order bin j of a frame tagged with base.
  function automatic sample_t bin_val(input int base, input int j);
    sample_t s;
    s.re = 16'(base + j);
    s.im = 16'(32'h8000 + 2 * base + 5 * j);
    return s;
  endfunction

  // Drive nframes back-to-back frames in bit-reversed order; di_en stays high
  // after the last sample until the caller idles.
  task automatic drive_frames(input int nframes, input int base);
    sample_t s;
    for (int f = 0; f < nframes; f++) begin
      for (int k = 0; k < N; k++) begin
        @(negedge clk);
        if (f == 0 && k == 0) sample0_cyc = cyc + 1;
        s     = bin_val(base + N * f, int'(rev4(LOG2N'(k))));
        di_en = 1'b1;
        di_re = s.re;
        di_im = s.im;
      end
      for (int j = 0; j < N; j++) sb.push_back(bin_val(base + N * f, j));
    end
  endtask

  task automatic drive_partial(input int len, input int base);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      di_en = 1'b1;
      di_re = 16'(base + k);
      di_im = 16'(base + 7 * k);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      di_en = 1'b0;
      di_re = '0;
      di_im = '0;
    end
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (sb.size() != 0 && i < 400) begin
      @(negedge clk);
      i++;
    end
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare outputs against the scoreboard and track burst shape.
  initial begin : monitor
    int      burst_len = 0;
    int      idle_len  = 0;
    sample_t exp_s;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        burst_len = 0;
        idle_len  = 0;
      end else if (do_en) begin
        if (burst_len == 0) begin
          if (lat_arm) begin
            check("first_output_latency", 32'(cyc - sample0_cyc), 32'd17);
            lat_arm = 1'b0;
          end
          if (exp_gap >= 0) begin
            check("inter_burst_gap", 32'(idle_len), 32'(exp_gap));
            exp_gap = -1;
          end
        end
        burst_len++;
        idle_len = 0;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual re=%h im=%h expected no output (t=%0t)",
                   do_re, do_im, $time);
        end else begin
          exp_s = sb.pop_front();
          check("do_data", {do_re, do_im}, exp_s);
        end
      end else begin
        check("zero_when_idle", {do_re, do_im}, 32'd0);
        if (burst_len != 0) begin
          check("burst_multiple_of_n", 32'(burst_len % N), 32'd0);
          if (exp_burst > 0) begin
            check("burst_len", 32'(burst_len), 32'(exp_burst));
            exp_burst = 0;
          end
          burst_len = 0;
        end
        idle_len++;
      end
    end
  end

  // A frame must never complete into a bank still awaiting readout.
  always @(posedge clk) begin
    if (rstn && di_en && dut.wcnt == LOG2N'(N - 1))
      check("no_overwrite_full_bank", 32'(dut.full[dut.wb]), 32'd0);
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    rstn = 1'b0;
    idle(3);
    check("reset_do_en", 32'(do_en), 32'd0);
    check("reset_do_data", {do_re, do_im}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // One frame: do_re = 0..15, first output 17 edges after sample 0.
    lat_arm = 1'b1;
    drive_frames(1, 0);
    idle(1);
    wait_drain("single_frame");
    idle(4);
    check("latency_seen", 32'(lat_arm), 32'd0);

    // Three back-to-back frames: one unbroken 48-cycle burst.
    exp_burst = 3 * N;
    drive_frames(3, 16'h0100);
    idle(1);
    wait_drain("three_frames");
    idle(4);
    check("burst48_seen", 32'(exp_burst), 32'd0);

    // Partial frame discarded, following full frame output alone.
    drive_partial(10, 16'h0500);
    idle(3);
    drive_frames(1, 16'h0200);
    idle(1);
    wait_drain("partial_then_full");
    idle(4);

    // Two frames separated by 5 idle edges: output bursts 5 apart.
    drive_frames(1, 16'h0300);
    idle(5);
    drive_frames(1, 16'h0340);
    exp_gap = 5;
    idle(1);
    wait_drain("gapped_frames");
    idle(4);
    check("gap_seen", 32'(exp_gap), 32'hFFFF_FFFF);

    // Reset while the reader sits at rcnt=7: output stops, buffer abandoned.
    drive_frames(1, 16'h0400);
    idle(9);
    #2 rstn = 1'b0;
    #1;
    check("midread_reset_do_en", 32'(do_en), 32'd0);
    check("midread_reset_do_data", {do_re, do_im}, 32'd0);
    check("midread_bins_left", 32'(sb.size()), 32'd9);
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle(30);
    drive_frames(1, 16'h0600);
    idle(1);
    wait_drain("after_reset");
    idle(4);

    check("final_queue_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
